// File: rtl/ama_riscv_perf_pkg.sv
// Shared definitions for the RISC-V test monitor.
// - state_t     : monitor FSM states (also visible on the debug state output)
// - STATUS_*    : encodings driven on the status output
// - TOHOST_PASS : tohost value that ends a test successfully
// - RD_SEL_*    : rd_sel base indices; they double as counter array indices
package ama_riscv_perf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam logic [1:0] STATUS_RUN     = 2'd0;
  localparam logic [1:0] STATUS_PASS    = 2'd1;
  localparam logic [1:0] STATUS_FAIL    = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

  localparam logic [31:0] TOHOST_PASS = 32'd1;

  localparam int RD_SEL_CYCLES   = 0;
  localparam int RD_SEL_RETIRED  = 1;
  localparam int RD_SEL_EVT_BASE = 2;

endpackage

// File: rtl/ama_riscv_sat_cnt.sv
// Saturating up-counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   i_clr      : synchronous clear, has priority over i_inc
//   i_inc      : increment by one unless already all-ones
//   o_cnt      : current count
module ama_riscv_sat_cnt #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ama_riscv_test_monitor.sv
// Test monitor for the RISC-V core: arms on start, counts cycles, retired
// instructions and generic events while running, and ends the run on a
// tohost write (pass/fail) or on watchdog expiry.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle pulse, (re)starts a run with counters cleared
//   retire, evt    : per-cycle strobes counted while running
//   tohost_we/wdata: tohost write; wdata[0]=1 terminates the run
//   timeout_lim    : RUN cycles allowed, 0 disables the watchdog
//   rd_sel/rd_data : registered counter readback (0 cycles, 1 retired, 2+i evt[i])
//   done/status    : registered terminal flag and result code
//   fail_code      : tohost_wdata[31:1] of the failing write
//   o_dbg_state    : current FSM state
//
// Handshake: there is no valid/ready pairing here; every input is a
// single-cycle strobe sampled on the rising edge, and outputs are registered.
module ama_riscv_test_monitor
  import ama_riscv_perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 48,
  parameter int TO_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               retire,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               tohost_we,
  input  logic [31:0]        tohost_wdata,
  input  logic [TO_W-1:0]    timeout_lim,
  input  logic [4:0]         rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic               done,
  output logic [1:0]         status,
  output logic [30:0]        fail_code,
  output logic [2:0]         o_dbg_state
);

  localparam int NUM_CNT = NUM_EVT + 2;

  state_t             r_state;
  logic [TO_W-1:0]    r_wdog;
  logic               r_done;
  logic [1:0]         r_status;
  logic [30:0]        r_fail_code;
  logic [CNT_W-1:0]   r_rd_data;

  logic               w_in_run;
  logic               w_term_wr;
  logic               w_wdog_exp;
  logic [NUM_CNT-1:0] w_inc;
  logic [CNT_W-1:0]   w_cnt [NUM_CNT];
  logic [CNT_W-1:0]   w_rd_next;

  assign w_in_run  = (r_state == ST_RUN);
  assign w_term_wr = tohost_we && tohost_wdata[0];
  // ">=" rather than "==" so lowering the limit mid-run still expires.
  assign w_wdog_exp = (timeout_lim != '0) && (r_wdog >= (timeout_lim - TO_W'(1)));

  // The exiting RUN cycle is still counted because inc only looks at the
  // current state; start clears inside the counter with priority.
  assign w_inc[RD_SEL_CYCLES]             = w_in_run;
  assign w_inc[RD_SEL_RETIRED]            = w_in_run & retire;
  assign w_inc[RD_SEL_EVT_BASE +: NUM_EVT] = {NUM_EVT{w_in_run}} & evt;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    ama_riscv_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (start),
      .i_inc (w_inc[g]),
      .o_cnt (w_cnt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wdog      <= '0;
      r_done      <= 1'b0;
      r_status    <= STATUS_RUN;
      r_fail_code <= '0;
    end else if (start) begin
      // start wins from every state, including RUN (restart).
      r_state     <= ST_RUN;
      r_wdog      <= '0;
      r_done      <= 1'b0;
      r_status    <= STATUS_RUN;
      r_fail_code <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_wdog <= r_wdog + TO_W'(1);
          // A terminating write beats a coincident watchdog expiry.
          if (w_term_wr) begin
            r_done <= 1'b1;
            if (tohost_wdata == TOHOST_PASS) begin
              r_state  <= ST_PASS;
              r_status <= STATUS_PASS;
            end else begin
              r_state     <= ST_FAIL;
              r_status    <= STATUS_FAIL;
              r_fail_code <= tohost_wdata[31:1];
            end
          end else if (w_wdog_exp) begin
            r_state  <= ST_TIMEOUT;
            r_done   <= 1'b1;
            r_status <= STATUS_TIMEOUT;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_next = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == 5'(i)) begin
        w_rd_next = w_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  assign rd_data     = r_rd_data;
  assign done        = r_done;
  assign status      = r_status;
  assign fail_code   = r_fail_code;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ama_riscv_test_monitor.sv
// Directed testbench for ama_riscv_test_monitor. A second instance with
// CNT_W=16 shares the stimulus and is used for the saturation scenario.
module tb_ama_riscv_test_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        retire;
  logic [3:0]  evt;
  logic        tohost_we;
  logic [31:0] tohost_wdata;
  logic [31:0] timeout_lim;
  logic [4:0]  rd_sel;

  logic [47:0] rd_data;
  logic        done;
  logic [1:0]  status;
  logic [30:0] fail_code;
  logic [2:0]  dbg_state;

  logic [15:0] rd_data_s;
  logic        done_s;
  logic [1:0]  status_s;
  logic [30:0] fail_code_s;
  logic [2:0]  dbg_state_s;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_PASS = 3'd2,
                         S_FAIL = 3'd3, S_TIMEOUT = 3'd4;

  ama_riscv_test_monitor #(.NUM_EVT(4), .CNT_W(48), .TO_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .retire(retire), .evt(evt),
    .tohost_we(tohost_we), .tohost_wdata(tohost_wdata), .timeout_lim(timeout_lim),
    .rd_sel(rd_sel), .rd_data(rd_data), .done(done), .status(status),
    .fail_code(fail_code), .o_dbg_state(dbg_state)
  );

  ama_riscv_test_monitor #(.NUM_EVT(4), .CNT_W(16), .TO_W(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .retire(retire), .evt(evt),
    .tohost_we(tohost_we), .tohost_wdata(tohost_wdata), .timeout_lim(timeout_lim),
    .rd_sel(rd_sel), .rd_data(rd_data_s), .done(done_s), .status(status_s),
    .fail_code(fail_code_s), .o_dbg_state(dbg_state_s)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #10_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left on a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic read_cnt(input logic [4:0] sel, output logic [47:0] v,
                          output logic [15:0] vs);
    rd_sel = sel;
    @(negedge clk);
    v  = rd_data;
    vs = rd_data_s;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_checks++; if (status !== 2'd0) begin n_fail++; $display("FAIL reset_status: got %0d want 0", status); end
    n_checks++; if (rd_data !== 48'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
    n_checks++; if (fail_code !== 31'd0) begin n_fail++; $display("FAIL reset_fail_code: got %0d want 0", fail_code); end
    n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d want %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_pass();
    logic [9:0]  ret_pat;
    logic [47:0] v;
    logic [15:0] vs;
    ret_pat = 10'b10_1101_1011;   // seven ones
    timeout_lim = 32'd0;
    do_start();
    for (int i = 0; i < 10; i++) begin
      retire = ret_pat[i];
      evt    = (i < 4) ? 4'b0010 : 4'b0000;
      @(negedge clk);
    end
    retire = 1'b0;
    evt = 4'b1000;
    tohost_we = 1'b1;
    tohost_wdata = 32'd1;
    @(negedge clk);
    tohost_we = 1'b0;
    evt = 4'b0000;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pass_done: got %0b want 1", done); end
    n_checks++; if (status !== 2'd1) begin n_fail++; $display("FAIL pass_status: got %0d want 1", status); end
    n_checks++; if (dbg_state !== S_PASS) begin n_fail++; $display("FAIL pass_state: got %0d want %0d", dbg_state, S_PASS); end
    read_cnt(5'd0, v, vs);
    n_checks++; if (v !== 48'd11) begin n_fail++; $display("FAIL pass_cycles: got %0d want 11", v); end
    read_cnt(5'd1, v, vs);
    n_checks++; if (v !== 48'd7) begin n_fail++; $display("FAIL pass_retired: got %0d want 7", v); end
    read_cnt(5'd3, v, vs);
    n_checks++; if (v !== 48'd4) begin n_fail++; $display("FAIL pass_evt1: got %0d want 4", v); end
    read_cnt(5'd5, v, vs);
    n_checks++; if (v !== 48'd1) begin n_fail++; $display("FAIL pass_evt3_exit_cycle: got %0d want 1", v); end
    read_cnt(5'd2, v, vs);
    n_checks++; if (v !== 48'd0) begin n_fail++; $display("FAIL pass_evt0: got %0d want 0", v); end
    read_cnt(5'd31, v, vs);
    n_checks++; if (v !== 48'd0) begin n_fail++; $display("FAIL unused_sel: got %0d want 0", v); end
    // Counters and state must hold while terminal.
    retire = 1'b1;
    evt = 4'b1111;
    repeat (3) @(negedge clk);
    retire = 1'b0;
    evt = 4'b0000;
    read_cnt(5'd1, v, vs);
    n_checks++; if (v !== 48'd7) begin n_fail++; $display("FAIL terminal_hold_retired: got %0d want 7", v); end
    n_checks++; if (dbg_state !== S_PASS) begin n_fail++; $display("FAIL terminal_hold_state: got %0d want %0d", dbg_state, S_PASS); end
  endtask

  task automatic test_fail();
    logic [47:0] v;
    logic [15:0] vs;
    do_start();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %0b want 0", done); end
    n_checks++; if (status !== 2'd0) begin n_fail++; $display("FAIL restart_status: got %0d want 0", status); end
    tohost_we = 1'b1;
    tohost_wdata = 32'h0000_0006;   // bit0 clear: ignored
    @(negedge clk);
    n_checks++; if (dbg_state !== S_RUN) begin n_fail++; $display("FAIL ignore_even_write: got %0d want %0d", dbg_state, S_RUN); end
    tohost_wdata = 32'h0000_0007;
    @(negedge clk);
    tohost_we = 1'b0;
    n_checks++; if (status !== 2'd2) begin n_fail++; $display("FAIL fail_status: got %0d want 2", status); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fail_done: got %0b want 1", done); end
    n_checks++; if (fail_code !== 31'd3) begin n_fail++; $display("FAIL fail_code: got %0d want 3", fail_code); end
    read_cnt(5'd0, v, vs);
    n_checks++; if (v !== 48'd2) begin n_fail++; $display("FAIL fail_cycles: got %0d want 2", v); end
  endtask

  task automatic test_timeout();
    logic [47:0] v;
    logic [15:0] vs;
    timeout_lim = 32'd5;
    do_start();
    repeat (4) @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %0b want 0", done); end
    @(negedge clk);
    n_checks++; if (status !== 2'd3) begin n_fail++; $display("FAIL timeout_status: got %0d want 3", status); end
    n_checks++; if (dbg_state !== S_TIMEOUT) begin n_fail++; $display("FAIL timeout_state: got %0d want %0d", dbg_state, S_TIMEOUT); end
    read_cnt(5'd0, v, vs);
    n_checks++; if (v !== 48'd5) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 5", v); end
    timeout_lim = 32'd0;
    do_start();
    repeat (1000) @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL no_timeout_done: got %0b want 0", done); end
    n_checks++; if (status !== 2'd0) begin n_fail++; $display("FAIL no_timeout_status: got %0d want 0", status); end
    read_cnt(5'd0, v, vs);
    n_checks++; if (v !== 48'd1000) begin n_fail++; $display("FAIL no_timeout_cycles: got %0d want 1000", v); end
  endtask

  task automatic test_race();
    logic [47:0] v;
    logic [15:0] vs;
    timeout_lim = 32'd3;
    do_start();
    repeat (2) @(negedge clk);
    tohost_we = 1'b1;
    tohost_wdata = 32'd1;
    @(negedge clk);
    tohost_we = 1'b0;
    n_checks++; if (status !== 2'd1) begin n_fail++; $display("FAIL race_status: got %0d want 1", status); end
    read_cnt(5'd0, v, vs);
    n_checks++; if (v !== 48'd3) begin n_fail++; $display("FAIL race_cycles: got %0d want 3", v); end
  endtask

  task automatic test_restart_in_run();
    logic [47:0] v;
    logic [15:0] vs;
    timeout_lim = 32'd0;
    do_start();
    retire = 1'b1;
    repeat (5) @(negedge clk);
    retire = 1'b0;
    do_start();
    retire = 1'b1;
    repeat (2) @(negedge clk);
    retire = 1'b0;
    read_cnt(5'd1, v, vs);
    n_checks++; if (v !== 48'd2) begin n_fail++; $display("FAIL restart_retired: got %0d want 2", v); end
    n_checks++; if (dbg_state !== S_RUN) begin n_fail++; $display("FAIL restart_state: got %0d want %0d", dbg_state, S_RUN); end
  endtask

  task automatic test_saturate();
    logic [47:0] v;
    logic [15:0] vs;
    timeout_lim = 32'd0;
    do_start();
    evt = 4'b0001;
    repeat (70000) @(negedge clk);
    evt = 4'b0000;
    read_cnt(5'd2, v, vs);
    n_checks++; if (vs !== 16'hFFFF) begin n_fail++; $display("FAIL sat_evt0_w16: got %0h want ffff", vs); end
    n_checks++; if (v !== 48'd70000) begin n_fail++; $display("FAIL evt0_w48: got %0d want 70000", v); end
    read_cnt(5'd0, v, vs);
    n_checks++; if (vs !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cycles_w16: got %0h want ffff", vs); end
  endtask

  task automatic test_async_reset();
    logic [47:0] v;
    logic [15:0] vs;
    timeout_lim = 32'd0;
    do_start();
    retire = 1'b1;
    rd_sel = 5'd1;
    repeat (4) @(negedge clk);
    // rd_data registered the count before the fourth edge.
    n_checks++; if (rd_data !== 48'd3) begin n_fail++; $display("FAIL pre_reset_rd_data: got %0d want 3", rd_data); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (rd_data !== 48'd0) begin n_fail++; $display("FAIL async_rd_data: got %0d want 0", rd_data); end
    n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL async_state: got %0d want %0d", dbg_state, S_IDLE); end
    n_checks++; if (done !== 1'b0 || status !== 2'd0) begin n_fail++; $display("FAIL async_done_status: got %0b/%0d want 0/0", done, status); end
    retire = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (dbg_state !== S_RUN) begin n_fail++; $display("FAIL first_start_after_reset: got %0d want %0d", dbg_state, S_RUN); end
    retire = 1'b1;
    repeat (3) @(negedge clk);
    retire = 1'b0;
    read_cnt(5'd1, v, vs);
    n_checks++; if (v !== 48'd3) begin n_fail++; $display("FAIL post_reset_retired: got %0d want 3", v); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    retire = 1'b0;
    evt = 4'b0000;
    tohost_we = 1'b0;
    tohost_wdata = 32'd0;
    timeout_lim = 32'd0;
    rd_sel = 5'd0;
    @(negedge clk);
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_race();
    test_restart_in_run();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
